nn_job_ctrl: RTL
================

Name: nn_job_ctrl

Overview:
Job sequencer between the UDP receive path, the frame-to-NN pixel buffer and the UDP transmit path. It accepts one inference job at a time and drops frames that arrive while busy. It starts the 28x28 pixel load into the buffer, then starts the NN when the load is done. When the NN reports a result, the controller hands the digit plus the latched sender addressing to the TX side. A watchdog aborts hung loads or inferences, and saturating status counters are exported for debug.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles allowed in LOAD or COMPUTE before abort; legal range 2..2^20-1
RESULT_W, 4, width of NN class result (digit 0-9)

Ports:
ACLK  in  1  clock
ARESET  in  1  reset, asynchronous, active-low
RX_FRAME_VALID  in  1  single-cycle pulse from UDP RX: new frame available
LOAD_START  out  1  frame-ready strobe to pixel buffer
LOAD_DONE  in  1  buffer's write-done pulse (last pixel written)
META_IP  in  32  sender IP from buffer
META_MAC  in  48  sender MAC from buffer
META_PORT  in  16  sender UDP port from buffer
NN_START  out  1  one-cycle inference start pulse
NN_DONE  in  1  one-cycle inference complete pulse
NN_RESULT  in  RESULT_W  class result, valid with NN_DONE
TX_VALID  out  1  reply valid
TX_READY  in  1  reply accepted by UDP TX
TX_IP  out  32  destination IP
TX_MAC  out  48  destination MAC
TX_PORT  out  16  destination UDP port
TX_RESULT  out  RESULT_W  reply payload
BUSY  out  1  high whenever state != IDLE
ERR_TIMEOUT  out  1  one-cycle pulse on watchdog abort
FRAMES_DONE  out  16  replies completed, saturating
FRAMES_DROPPED  out  16  frames rejected while busy, saturating
TIMEOUTS  out  16  watchdog aborts, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; all counters 0; watchdog 0; latched meta/result 0.
- States: IDLE, LOAD, COMPUTE, REPLY.
- IDLE: LOAD_START = RX_FRAME_VALID (combinational, gated by state==IDLE), so the buffer captures the frame in the same cycle. On RX_FRAME_VALID, next state is LOAD.
- LOAD: waits for LOAD_DONE.
  - On LOAD_DONE: latch META_IP/MAC/PORT into internal registers; next state COMPUTE.
  - NN_START is registered and asserted for exactly the first cycle spent in COMPUTE.
- COMPUTE: on NN_DONE, latch NN_RESULT; next state REPLY.
- REPLY:
  - TX_VALID=1; TX_* driven from latched registers and held stable while TX_VALID && !TX_READY.
  - On TX_VALID && TX_READY: FRAMES_DONE++; next state IDLE. TX_VALID deasserts the next cycle.
  - No timeout in REPLY; waits indefinitely.
- Watchdog: cleared on every state transition; increments each cycle in LOAD or COMPUTE.
  - When it equals TIMEOUT_CYCLES-1 and no completing event (LOAD_DONE / NN_DONE) occurs that cycle: next state IDLE, ERR_TIMEOUT pulses one cycle, TIMEOUTS++, no reply.
  - A completing event in the expiry cycle wins over the timeout.
- Drops: RX_FRAME_VALID in any state other than IDLE gives FRAMES_DROPPED++ and LOAD_START stays 0. This includes the REPLY handshake cycle. A frame in the first IDLE cycle after it is accepted.
- Stray pulses: LOAD_DONE outside LOAD and NN_DONE outside COMPUTE are ignored (no state change, no latch).
- Counters saturate at 16'hFFFF and never wrap.
- Reset mid-job (any state): immediate return to IDLE, outputs 0, counters cleared; no reply emitted after reset release.
- Latency, happy path: RX pulse at cycle 0 gives LOAD_START at cycle 0. LOAD_DONE at cycle N gives NN_START at cycle N+1. NN_DONE at cycle M gives TX_VALID from cycle M+1.

Test Plan:
- Happy path: RX pulse at T0, LOAD_DONE at T0+786, NN_DONE with result 7 at T0+900, TX_READY held 1 -> LOAD_START at T0, NN_START exactly at T0+787, TX_VALID one cycle at T0+901 with TX_RESULT=7 and latched IP/MAC/PORT, FRAMES_DONE=1, BUSY low at T0+902.
- Drop while busy: 3 RX pulses during LOAD, 1 during the REPLY handshake cycle -> no extra LOAD_START, FRAMES_DROPPED=4, single reply; RX in the next IDLE cycle is accepted.
- Timeout: TIMEOUT_CYCLES=16, never assert NN_DONE -> ERR_TIMEOUT pulse 16 cycles after COMPUTE entry, TIMEOUTS=1, state IDLE, TX_VALID never asserted; NN_DONE in the exact expiry cycle instead -> REPLY, no timeout.
- Backpressure: TX_READY low for 10 cycles -> TX_VALID and TX_* stable for all 10 cycles; change META_* inputs meanwhile -> TX_* unchanged; handshake on cycle 11.
- Stray/reset: NN_DONE in IDLE and LOAD_DONE in COMPUTE -> ignored; ARESET low mid-COMPUTE -> all outputs and counters 0, no reply after release.
- Saturation: force 65537 drops -> FRAMES_DROPPED holds 16'hFFFF.

Source files
------------

// File: rtl/nn_job_ctrl.sv
// Inference job sequencer: one frame at a time from UDP RX through pixel load,
// NN compute and TX reply, with a load/compute watchdog and saturating debug counters.
module nn_job_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned RESULT_W       = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                RX_FRAME_VALID,
  output logic                LOAD_START,
  input  logic                LOAD_DONE,
  input  logic [31:0]         META_IP,
  input  logic [47:0]         META_MAC,
  input  logic [15:0]         META_PORT,
  output logic                NN_START,
  input  logic                NN_DONE,
  input  logic [RESULT_W-1:0] NN_RESULT,
  output logic                TX_VALID,
  input  logic                TX_READY,
  output logic [31:0]         TX_IP,
  output logic [47:0]         TX_MAC,
  output logic [15:0]         TX_PORT,
  output logic [RESULT_W-1:0] TX_RESULT,
  output logic                BUSY,
  output logic                ERR_TIMEOUT,
  output logic [15:0]         FRAMES_DONE,
  output logic [15:0]         FRAMES_DROPPED,
  output logic [15:0]         TIMEOUTS
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_REPLY   = 2'd3
  } state_t;

  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 32'd1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                state_q, state_d;
  logic [19:0]           wd_q, wd_d;
  logic [31:0]           ip_q, ip_d;
  logic [47:0]           mac_q, mac_d;
  logic [15:0]           port_q, port_d;
  logic [RESULT_W-1:0]   res_q, res_d;
  logic                  nn_start_q, nn_start_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  err_q, err_d;
  logic [15:0]           done_q, done_d;
  logic [15:0]           drop_q, drop_d;
  logic [15:0]           to_q, to_d;
  logic                  wd_expired_s;

  assign wd_expired_s = (wd_q == WD_LAST);

  // Next-state decode; the watchdog defaults to zero so every transition clears it.
  always_comb begin
    state_d    = state_q;
    wd_d       = 20'd0;
    ip_d       = ip_q;
    mac_d      = mac_q;
    port_d     = port_q;
    res_d      = res_q;
    nn_start_d = 1'b0;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    done_d     = done_q;
    to_d       = to_q;
    if (RX_FRAME_VALID && (state_q != S_IDLE)) begin
      drop_d = sat_inc(drop_q);
    end else begin
      drop_d = drop_q;
    end
    case (state_q)
      S_IDLE: begin
        if (RX_FRAME_VALID) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // A completion in the expiry cycle takes priority over the abort.
        if (LOAD_DONE) begin
          ip_d       = META_IP;
          mac_d      = META_MAC;
          port_d     = META_PORT;
          nn_start_d = 1'b1;
          state_d    = S_COMPUTE;
        end else if (wd_expired_s) begin
          err_d   = 1'b1;
          to_d    = sat_inc(to_q);
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 20'd1;
        end
      end
      S_COMPUTE: begin
        if (NN_DONE) begin
          res_d      = NN_RESULT;
          tx_valid_d = 1'b1;
          state_d    = S_REPLY;
        end else if (wd_expired_s) begin
          err_d   = 1'b1;
          to_d    = sat_inc(to_q);
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 20'd1;
        end
      end
      S_REPLY: begin
        if (TX_READY) begin
          done_d  = sat_inc(done_q);
          state_d = S_IDLE;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single state/output register bank.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q    <= S_IDLE;
      wd_q       <= 20'd0;
      ip_q       <= 32'd0;
      mac_q      <= 48'd0;
      port_q     <= 16'd0;
      res_q      <= '0;
      nn_start_q <= 1'b0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 16'd0;
      drop_q     <= 16'd0;
      to_q       <= 16'd0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      ip_q       <= ip_d;
      mac_q      <= mac_d;
      port_q     <= port_d;
      res_q      <= res_d;
      nn_start_q <= nn_start_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      to_q       <= to_d;
    end
  end

  // The buffer must see the strobe in the same cycle the RX pulse arrives.
  assign LOAD_START     = RX_FRAME_VALID && (state_q == S_IDLE);
  assign NN_START       = nn_start_q;
  assign TX_VALID       = tx_valid_q;
  assign TX_IP          = ip_q;
  assign TX_MAC         = mac_q;
  assign TX_PORT        = port_q;
  assign TX_RESULT      = res_q;
  assign BUSY           = (state_q != S_IDLE);
  assign ERR_TIMEOUT    = err_q;
  assign FRAMES_DONE    = done_q;
  assign FRAMES_DROPPED = drop_q;
  assign TIMEOUTS       = to_q;

endmodule
